// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default element width, window position codes,
// and signed max / ReLU helpers used by the conv, pool and fc stages.
package cnn_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int CALC_W         = 64;

    // Helpers work on a wide signed type so any element width up to CALC_W can share them.
    typedef logic signed [CALC_W-1:0] calc_t;

    // Position of a pixel inside its 2x2 window: {row[0], col[0]}.
    typedef enum logic [1:0] {
        QUAD_EE = 2'b00,
        QUAD_EO = 2'b01,
        QUAD_OE = 2'b10,
        QUAD_OO = 2'b11
    } quad_e;

    function automatic calc_t smax(input calc_t a, input calc_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic calc_t relu(input calc_t x, input logic en);
        return (en && (x < 0)) ? '0 : x;
    endfunction

endpackage

// File: rtl/relu_maxpool_stream_pool_lane.sv
// One channel of the pooling datapath: signed 2-input max for the line buffer
// and signed 3-input max followed by optional ReLU for the window result.
module pool_lane
    import cnn_pkg::*;
#(
    parameter int W       = DEFAULT_DATA_W,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] max2_o,
    output logic [W-1:0] max3_o
);

    calc_t a_x, b_x, c_x;

    assign a_x = calc_t'(signed'(a_i));
    assign b_x = calc_t'(signed'(b_i));
    assign c_x = calc_t'(signed'(c_i));

    assign max2_o = W'(smax(b_x, c_x));
    assign max3_o = W'(relu(smax(a_x, smax(b_x, c_x)), RELU_EN));

endmodule

// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + 2x2/stride-2 max-pool: pairs rows through a half-width line buffer
// and emits one pooled beat per completed window with one cycle of latency.
module relu_maxpool_stream
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH = 28,
    parameter int CHANNELS = 16,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_last,
    output logic                         frame_err
);

    localparam int              CW   = $clog2(IN_WIDTH);
    localparam int              BW   = CHANNELS * DATA_W;
    localparam logic [CW-1:0]   LAST = CW'(IN_WIDTH - 1);

    if ((IN_WIDTH % 2) != 0 || IN_WIDTH < 4) begin : g_bad_width
        $error("relu_maxpool_stream: IN_WIDTH must be even and at least 4");
    end

    logic [CW-1:0] row_q, col_q, row_d, col_d;
    logic [BW-1:0] pair_q;
    logic [BW-1:0] linebuf_q [IN_WIDTH/2];
    logic [BW-1:0] lb_rd, max2, max3;
    logic          out_valid_q, out_last_q, frame_err_q;
    logic [BW-1:0] out_data_q;
    logic          accept, at_end, early_last, missing_last, load;
    quad_e         quad;

    assign in_ready     = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign at_end       = (row_q == LAST) && (col_q == LAST);
    assign early_last   = accept && in_last && !at_end;
    assign missing_last = accept && !in_last && at_end;
    assign quad         = quad_e'({row_q[0], col_q[0]});
    assign lb_rd        = linebuf_q[col_q[CW-1:1]];
    // A premature in_last aborts the frame, so that beat never touches the datapath.
    assign load         = accept && !early_last;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (early_last) begin
            row_d = '0;
            col_d = '0;
        end else if (accept) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        pool_lane #(
            .W       (DATA_W),
            .RELU_EN (RELU_EN)
        ) u_lane (
            .a_i    (lb_rd  [ch*DATA_W +: DATA_W]),
            .b_i    (pair_q [ch*DATA_W +: DATA_W]),
            .c_i    (in_data[ch*DATA_W +: DATA_W]),
            .max2_o (max2   [ch*DATA_W +: DATA_W]),
            .max3_o (max3   [ch*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (load) begin
            if (quad == QUAD_EE || quad == QUAD_OE) begin
                pair_q <= in_data;
            end
            if (quad == QUAD_EO) begin
                linebuf_q[col_q[CW-1:1]] <= max2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            frame_err_q <= early_last || missing_last;
            if (load && quad == QUAD_OO) begin
                out_valid_q <= 1'b1;
                out_data_q  <= max3;
                out_last_q  <= at_end;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule
